// File: rtl/multi_slot_pkt_fifo_ctrl_if.sv
// Bundle of the datapath in/out handshakes and the CPU register-access port
// of the multi-slot packet buffer.
interface multi_slot_pkt_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;
  logic [63:0]           cpu_addr_in;
  logic [63:0]           cpu_din;
  logic                  cpu_wen;
  logic [63:0]           cpu_dout;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy, cpu_addr_in, cpu_din, cpu_wen,
    input  in_rdy, out_data, out_ctrl, out_wr, cpu_dout
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy, cpu_addr_in, cpu_din, cpu_wen,
    output in_rdy, out_data, out_ctrl, out_wr, cpu_dout
  );
endinterface

// File: rtl/multi_slot_pkt_fifo_ctrl.sv
// Packet buffer with NUM_SLOTS rotating slots: one fills from the datapath,
// one is owned by the CPU and one drains to the output, in arrival order.
module multi_slot_pkt_fifo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_SLOTS  = 2,
  parameter int SLOT_BITS  = $clog2(NUM_SLOTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  multi_slot_pkt_fifo_ctrl_if.slave bus
);
  localparam int MEM_WORDS = NUM_SLOTS * (1 << ADDR_WIDTH);

  typedef enum logic [1:0] {SLOT_FREE, SLOT_FILL, SLOT_CPU, SLOT_DRAIN} slot_state_t;
  typedef enum logic [1:0] {IN_IDLE, IN_HEADER, IN_PAYLOAD, IN_DISCARD} in_state_t;
  typedef enum logic [1:0] {DR_IDLE, DR_RUN, DR_DONE} drain_state_t;

  slot_state_t           slot_state [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] head [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] tail [NUM_SLOTS];
  logic [SLOT_BITS-1:0]  wr_idx, cpu_idx, drain_idx;
  in_state_t             in_state;
  drain_state_t          dr_state;
  logic                  live, disc_payload;
  logic [15:0]           drop_cnt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data [MEM_WORDS];
  logic [CTRL_WIDTH-1:0] mem_ctrl [MEM_WORDS];

  logic                            in_has_ctrl, accept, is_eop, overflow, store;
  logic [SLOT_BITS+ADDR_WIDTH-1:0] store_addr, cpu_addr, dr_addr;
  logic                            cpu_ctrl, cpu_valid, cpu_data_wr, cpu_ctrl_wr, cpu_done;
  logic [1:0]                      cpu_cmd;
  logic [ADDR_WIDTH-1:0]           cpu_word;
  logic [63:0]                     status, cpu_rdata;
  logic                            drain_issue, drain_last;
  logic                            unused_ok;

  assign unused_ok   = ^{bus.cpu_addr_in, bus.cpu_din};

  assign in_has_ctrl = bus.in_ctrl != '0;
  assign bus.in_rdy  = live && (in_state != IN_IDLE || slot_state[wr_idx] == SLOT_FREE);
  assign accept      = bus.in_wr && bus.in_rdy;
  assign is_eop      = in_state == IN_PAYLOAD && in_has_ctrl;
  assign overflow    = accept && (in_state == IN_HEADER || in_state == IN_PAYLOAD)
                       && tail[wr_idx] == {ADDR_WIDTH{1'b1}} && !is_eop;
  assign store       = accept && !overflow && ((in_state == IN_IDLE && in_has_ctrl)
                       || in_state == IN_HEADER || in_state == IN_PAYLOAD);
  assign store_addr  = {wr_idx, (in_state == IN_IDLE) ? {ADDR_WIDTH{1'b0}} : tail[wr_idx]};

  assign cpu_ctrl    = bus.cpu_addr_in[ADDR_WIDTH+2];
  assign cpu_cmd     = bus.cpu_addr_in[ADDR_WIDTH+1:ADDR_WIDTH];
  assign cpu_word    = bus.cpu_addr_in[ADDR_WIDTH-1:0];
  assign cpu_addr    = {cpu_idx, cpu_word};
  assign cpu_valid   = slot_state[cpu_idx] == SLOT_CPU;
  assign cpu_data_wr = bus.cpu_wen && cpu_valid && !cpu_ctrl && cpu_cmd == 2'b00;
  assign cpu_ctrl_wr = bus.cpu_wen && cpu_valid && !cpu_ctrl && cpu_cmd == 2'b01;
  assign cpu_done    = bus.cpu_wen && cpu_valid && cpu_ctrl && cpu_cmd == 2'b11;

  assign drain_issue = dr_state == DR_RUN && bus.out_rdy;
  assign drain_last  = rd_ptr == tail[drain_idx] - ADDR_WIDTH'(1);
  assign dr_addr     = {drain_idx, rd_ptr};

  always_comb begin
    status = '0;
    for (int i = 0; i < NUM_SLOTS; i++) status[2*i +: 2] = slot_state[i];
    status[2*NUM_SLOTS]        = cpu_valid;
    status[2*NUM_SLOTS+1 +: 16] = drop_cnt;
  end

  always_comb begin
    cpu_rdata = '0;
    if (!cpu_ctrl) begin
      if (cpu_cmd == 2'b00)      cpu_rdata = 64'(mem_data[cpu_addr]);
      else if (cpu_cmd == 2'b01) cpu_rdata = 64'(mem_ctrl[cpu_addr]);
    end else begin
      case (cpu_cmd)
        2'b00:   cpu_rdata = 64'(tail[cpu_idx]);
        2'b01:   cpu_rdata = 64'(head[cpu_idx]);
        2'b10:   cpu_rdata = status;
        default: cpu_rdata = '0;
      endcase
    end
  end

  // Port A carries input writes and CPU accesses; they always target different slots.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_data[store_addr] <= bus.in_data;
      mem_ctrl[store_addr] <= bus.in_ctrl;
    end
    if (cpu_data_wr) mem_data[cpu_addr] <= bus.cpu_din[DATA_WIDTH-1:0];
    if (cpu_ctrl_wr) mem_ctrl[cpu_addr] <= bus.cpu_din[CTRL_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_state[i] <= SLOT_FREE;
        head[i]       <= '0;
        tail[i]       <= '0;
      end
      wr_idx       <= '0;
      cpu_idx      <= '0;
      drain_idx    <= '0;
      in_state     <= IN_IDLE;
      dr_state     <= DR_IDLE;
      live         <= 1'b0;
      disc_payload <= 1'b0;
      drop_cnt     <= '0;
      rd_ptr       <= '0;
      bus.out_wr   <= 1'b0;
      bus.out_data <= '0;
      bus.out_ctrl <= '0;
      bus.cpu_dout <= '0;
    end else begin
      live         <= 1'b1;
      bus.cpu_dout <= cpu_rdata;
      bus.out_wr   <= drain_issue;
      if (drain_issue) begin
        bus.out_data <= mem_data[dr_addr];
        bus.out_ctrl <= mem_ctrl[dr_addr];
      end

      if (accept) begin
        case (in_state)
          IN_IDLE: if (in_has_ctrl) begin
            head[wr_idx]       <= '0;
            tail[wr_idx]       <= ADDR_WIDTH'(1);
            slot_state[wr_idx] <= SLOT_FILL;
            in_state           <= IN_HEADER;
          end
          IN_HEADER, IN_PAYLOAD: begin
            if (overflow) begin
              slot_state[wr_idx] <= SLOT_FREE;
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              disc_payload <= (in_state == IN_PAYLOAD) || !in_has_ctrl;
              in_state     <= IN_DISCARD;
            end else begin
              tail[wr_idx] <= tail[wr_idx] + ADDR_WIDTH'(1);
              if (in_state == IN_HEADER && !in_has_ctrl) in_state <= IN_PAYLOAD;
              if (is_eop) begin
                slot_state[wr_idx] <= SLOT_CPU;
                wr_idx             <= wr_idx + SLOT_BITS'(1);
                in_state           <= IN_IDLE;
              end
            end
          end
          default: begin
            if (!in_has_ctrl)      disc_payload <= 1'b1;
            else if (disc_payload) in_state     <= IN_IDLE;
          end
        endcase
      end

      if (cpu_done) begin
        slot_state[cpu_idx] <= SLOT_DRAIN;
        cpu_idx             <= cpu_idx + SLOT_BITS'(1);
      end else if (bus.cpu_wen && cpu_valid && cpu_ctrl) begin
        if (cpu_cmd == 2'b00)      tail[cpu_idx] <= bus.cpu_din[ADDR_WIDTH-1:0];
        else if (cpu_cmd == 2'b01) head[cpu_idx] <= bus.cpu_din[ADDR_WIDTH-1:0];
      end

      // The slot is released only once its final word has left the output register.
      case (dr_state)
        DR_IDLE: if (slot_state[drain_idx] == SLOT_DRAIN) begin
          if (head[drain_idx] >= tail[drain_idx]) begin
            slot_state[drain_idx] <= SLOT_FREE;
            drain_idx             <= drain_idx + SLOT_BITS'(1);
          end else begin
            rd_ptr   <= head[drain_idx];
            dr_state <= DR_RUN;
          end
        end
        DR_RUN: if (drain_issue) begin
          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
          if (drain_last) dr_state <= DR_DONE;
        end
        DR_DONE: begin
          slot_state[drain_idx] <= SLOT_FREE;
          drain_idx             <= drain_idx + SLOT_BITS'(1);
          dr_state              <= DR_IDLE;
        end
        default: dr_state <= DR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_slot_pkt_fifo_ctrl.sv
// Directed bench for the multi-slot packet buffer: packets in, CPU register
// traffic, and a scoreboard of expected output words.
module tb_multi_slot_pkt_fifo_ctrl;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int AW = 4;
  localparam int NS = 2;
  localparam logic [1:0] ST_FREE = 2'd0, ST_FILL = 2'd1, ST_CPU = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_q[$];
  logic [71:0] pkt[$];
  logic [63:0] rd;

  multi_slot_pkt_fifo_ctrl_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  multi_slot_pkt_fifo_ctrl #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_SLOTS(NS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every emitted word must be the oldest outstanding expected word.
  always @(negedge clk) begin
    if (reset && bus.out_wr === 1'b1) begin
      if (exp_q.size() == 0) check_output("out_wr_extra", 72'(bus.out_wr), 72'd0);
      else check_output("out_word", {bus.out_ctrl, bus.out_data}, exp_q.pop_front());
    end
  end

  function automatic logic [63:0] reg_addr(input logic [1:0] cmd);
    return (64'd1 << (AW + 2)) | (64'(cmd) << AW);
  endfunction

  function automatic logic [63:0] ctrl_addr(input int w);
    return (64'd1 << AW) | 64'(w);
  endfunction

  function automatic logic [63:0] exp_status(input logic [15:0] drop, input logic valid,
                                             input logic [1:0] s1, input logic [1:0] s0);
    return 64'({drop, valid, s1, s0});
  endfunction

  task automatic apply_stimulus(input logic [63:0] d, input logic [7:0] c);
    int n = 0;
    bus.in_data = d;
    bus.in_ctrl = c;
    bus.in_wr   = 1'b1;
    @(negedge clk);
    while (bus.in_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("in_rdy_wait", 72'(bus.in_rdy), 72'd1);
    @(posedge clk);
    #1;
    bus.in_wr = 1'b0;
  endtask

  task automatic make_pkt(input int n_hdr, input int n_data, input logic [63:0] base);
    pkt.delete();
    for (int i = 0; i < n_hdr; i++) pkt.push_back({8'hFF, base + 64'(i)});
    for (int i = 0; i < n_data; i++) pkt.push_back({8'h00, base + 64'(n_hdr + i)});
    pkt.push_back({8'h01, base + 64'(n_hdr + n_data)});
  endtask

  task automatic send_pkt(input bit push);
    foreach (pkt[i]) begin
      if (push) exp_q.push_back(pkt[i]);
      apply_stimulus(pkt[i][63:0], pkt[i][71:64]);
    end
  endtask

  task automatic cpu_write(input logic [63:0] a, input logic [63:0] d);
    bus.cpu_addr_in = a;
    bus.cpu_din     = d;
    bus.cpu_wen     = 1'b1;
    @(posedge clk);
    #1;
    bus.cpu_wen = 1'b0;
  endtask

  task automatic cpu_read(input logic [63:0] a, output logic [63:0] d);
    bus.cpu_addr_in = a;
    bus.cpu_wen     = 1'b0;
    @(posedge clk);
    #1;
    d = bus.cpu_dout;
  endtask

  task automatic wait_drain(input int remain, input bit toggle);
    int n = 0;
    while (exp_q.size() > remain && n < 400) begin
      @(posedge clk);
      #1;
      if (toggle) bus.out_rdy = ~bus.out_rdy;
      n++;
    end
    bus.out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("drain_left", 72'(exp_q.size()), 72'(remain));
  endtask

  initial begin
    bus.in_data = '0;
    bus.in_ctrl = '0;
    bus.in_wr = 1'b0;
    bus.out_rdy = 1'b1;
    bus.cpu_addr_in = '0;
    bus.cpu_din = '0;
    bus.cpu_wen = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_in_rdy", 72'(bus.in_rdy), 72'd0);
    check_output("rst_out_wr", 72'(bus.out_wr), 72'd0);
    check_output("rst_out_data", {bus.out_ctrl, bus.out_data}, 72'd0);
    check_output("rst_cpu_dout", 72'(bus.cpu_dout), 72'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("rel_in_rdy", 72'(bus.in_rdy), 72'd1);
    cpu_read(reg_addr(2'b10), rd);
    check_output("rst_status", 72'(rd), 72'(exp_status(16'd0, 1'b0, ST_FREE, ST_FREE)));

    // Single packet: 2 headers, 5 data words, EOP
    make_pkt(2, 5, 64'h1000);
    send_pkt(1'b1);
    cpu_read(reg_addr(2'b10), rd);
    check_output("p1_status", 72'(rd), 72'(exp_status(16'd0, 1'b1, ST_FREE, ST_CPU)));
    cpu_read(reg_addr(2'b00), rd);
    check_output("p1_tail", 72'(rd), 72'd8);
    cpu_read(reg_addr(2'b01), rd);
    check_output("p1_head", 72'(rd), 72'd0);
    cpu_read(64'd3, rd);
    check_output("p1_word3", 72'(rd), 72'(64'h1003));
    cpu_read(ctrl_addr(0), rd);
    check_output("p1_ctrl0", 72'(rd), 72'hFF);
    cpu_write(reg_addr(2'b11), 64'd0);
    wait_drain(0, 1'b0);
    cpu_read(reg_addr(2'b10), rd);
    check_output("p1_freed", 72'(rd), 72'(exp_status(16'd0, 1'b0, ST_FREE, ST_FREE)));

    // Three packets with only two slots: the third stalls until the first drains
    make_pkt(1, 2, 64'hA000);
    send_pkt(1'b1);
    make_pkt(1, 3, 64'hB000);
    send_pkt(1'b1);
    cpu_read(reg_addr(2'b10), rd);
    check_output("ab_status", 72'(rd), 72'(exp_status(16'd0, 1'b1, ST_CPU, ST_CPU)));
    make_pkt(1, 1, 64'hC000);
    bus.in_data = pkt[0][63:0];
    bus.in_ctrl = pkt[0][71:64];
    bus.in_wr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("c_stalled", 72'(bus.in_rdy), 72'd0);
    @(posedge clk);
    #1;
    cpu_write(reg_addr(2'b11), 64'd0);
    send_pkt(1'b1);
    cpu_write(reg_addr(2'b11), 64'd0);
    wait_drain(3, 1'b0);
    cpu_write(reg_addr(2'b11), 64'd0);
    wait_drain(0, 1'b0);

    // CPU overwrites word 3 and trims the head to word 1
    make_pkt(1, 6, 64'hD000);
    send_pkt(1'b0);
    cpu_write(64'd3, 64'hDEADBEEF);
    cpu_write(reg_addr(2'b01), 64'd1);
    cpu_read(reg_addr(2'b01), rd);
    check_output("d_head", 72'(rd), 72'd1);
    cpu_read(64'd3, rd);
    check_output("d_word3", 72'(rd), 72'(64'hDEADBEEF));
    pkt[3][63:0] = 64'hDEADBEEF;
    for (int i = 1; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
    cpu_write(reg_addr(2'b11), 64'd0);
    wait_drain(0, 1'b0);

    // A 20-word packet overflows a 16-word slot and is dropped
    make_pkt(1, 18, 64'hE000);
    send_pkt(1'b0);
    cpu_read(reg_addr(2'b10), rd);
    check_output("ovf_status", 72'(rd), 72'(exp_status(16'd1, 1'b0, ST_FREE, ST_FREE)));
    make_pkt(1, 4, 64'hF000);
    send_pkt(1'b1);
    cpu_read(reg_addr(2'b10), rd);
    check_output("post_ovf_status", 72'(rd), 72'(exp_status(16'd1, 1'b1, ST_CPU, ST_FREE)));
    cpu_read(reg_addr(2'b00), rd);
    check_output("post_ovf_tail", 72'(rd), 72'd6);
    cpu_write(reg_addr(2'b11), 64'd0);
    wait_drain(0, 1'b0);

    // Output backpressure toggling every cycle
    make_pkt(2, 4, 64'h5000);
    send_pkt(1'b1);
    cpu_write(reg_addr(2'b11), 64'd0);
    wait_drain(0, 1'b1);

    // Reset in the middle of a packet's payload
    make_pkt(1, 3, 64'h6000);
    void'(pkt.pop_back());
    send_pkt(1'b0);
    cpu_read(reg_addr(2'b10), rd);
    check_output("mid_status", 72'(rd), 72'(exp_status(16'd1, 1'b0, ST_FILL, ST_FREE)));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("mid_rst_in_rdy", 72'(bus.in_rdy), 72'd0);
    check_output("mid_rst_out_wr", 72'(bus.out_wr), 72'd0);
    reset = 1'b1;
    cpu_read(reg_addr(2'b10), rd);
    check_output("mid_rst_status", 72'(rd), 72'(exp_status(16'd0, 1'b0, ST_FREE, ST_FREE)));
    make_pkt(1, 3, 64'h7000);
    send_pkt(1'b1);
    cpu_read(reg_addr(2'b10), rd);
    check_output("after_rst_status", 72'(rd), 72'(exp_status(16'd0, 1'b1, ST_FREE, ST_CPU)));
    cpu_read(reg_addr(2'b00), rd);
    check_output("after_rst_tail", 72'(rd), 72'd5);
    cpu_write(reg_addr(2'b11), 64'd0);
    wait_drain(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
